// File: rtl/seq_restoring_divider.sv
// Iterative restoring divider: one quotient bit per clock, one shared subtractor.
// Optional two's-complement mode is enabled by defining DIV_SIGNED_EN.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             dbz_q, dbz_d;
    logic [WIDTH-1:0] quo_hold_q, quo_hold_d;
    logic [WIDTH-1:0] rem_hold_q, rem_hold_d;
    logic             dbz_hold_q, dbz_hold_d;

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;

    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH-1:0] res_quo, res_rem;

`ifdef DIV_SIGNED_EN
    logic qneg_q, qneg_d;
    logic rneg_q, rneg_d;

    function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v);
        logic [WIDTH-1:0] u;
        u = v;
        return v[WIDTH-1] ? (~u + WIDTH'(1)) : u;
    endfunction

    // The most-negative magnitude negates onto itself, giving the wrapped quotient.
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
        logic signed [WIDTH-1:0] s;
        s = $signed(mag);
        return neg ? $unsigned(-s) : mag;
    endfunction

    assign dvd_mag = abs_val(dividend);
    assign dvs_mag = abs_val(divisor);
    assign res_quo = dbz_q ? quo_q : apply_sign(quo_q, qneg_q);
    assign res_rem = dbz_q ? rem_q : apply_sign(rem_q, rneg_q);
`else
    assign dvd_mag = dividend;
    assign dvs_mag = divisor;
    assign res_quo = quo_q;
    assign res_rem = rem_q;
`endif

    // Partial remainder stays below the divisor, so the low WIDTH bits of the difference suffice.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign fits    = shifted >= {1'b0, dvs_q};
    assign diff    = shifted[WIDTH-1:0] - dvs_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dbz_d      = dbz_q;
        quo_hold_d = quo_hold_q;
        rem_hold_d = rem_hold_q;
        dbz_hold_d = dbz_hold_q;
        rem_d      = rem_q;
        quo_d      = quo_q;
        dvs_d      = dvs_q;
`ifdef DIV_SIGNED_EN
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    dvs_d = dvs_mag;
`ifdef DIV_SIGNED_EN
                    qneg_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    rneg_d = dividend[WIDTH-1];
`endif
                    if (divisor == '0) begin
                        dbz_d   = 1'b1;
                        quo_d   = '1;
                        rem_d   = dividend;
                        state_d = DONE;
                    end else begin
                        dbz_d   = 1'b0;
                        quo_d   = dvd_mag;
                        rem_d   = '0;
                        cnt_d   = CW'(WIDTH);
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                rem_d = fits ? diff : shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], fits};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                quo_hold_d = res_quo;
                rem_hold_d = res_rem;
                dbz_hold_d = dbz_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dbz_q      <= 1'b0;
            quo_hold_q <= '0;
            rem_hold_q <= '0;
            dbz_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dbz_q      <= dbz_d;
            quo_hold_q <= quo_hold_d;
            rem_hold_q <= rem_hold_d;
            dbz_hold_q <= dbz_hold_d;
        end
    end

    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dvs_q <= dvs_d;
`ifdef DIV_SIGNED_EN
        qneg_q <= qneg_d;
        rneg_q <= rneg_d;
`endif
    end

    // Results are presented live during DONE and held from the registers afterwards.
    assign done        = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign quotient    = done ? res_quo : quo_hold_q;
    assign remainder   = done ? res_rem : rem_hold_q;
    assign div_by_zero = done ? dbz_q : dbz_hold_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep checks of seq_restoring_divider at WIDTH=8 and WIDTH=4.
// Signed expectations are selected when DIV_SIGNED_EN is defined.
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, start4;
    logic [7:0] dividend, divisor;
    logic [3:0] dividend4, divisor4;
    logic       busy, done, dbz;
    logic [7:0] quotient, remainder;
    logic       busy4, done4, dbz4;
    logic [3:0] quotient4, remainder4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(8)) u_dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(dbz)
    );

    seq_restoring_divider #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .dividend(dividend4), .divisor(divisor4),
        .busy(busy4), .done(done4),
        .quotient(quotient4), .remainder(remainder4), .div_by_zero(dbz4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // Returns the index of the cycle (1 = cycle after the start edge) in which done was seen.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge clk);
        dividend = a; divisor = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] b, output int lat);
        @(negedge clk);
        dividend4 = a; divisor4 = b; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Reference {dbz, quotient, remainder} for a w-bit divider.
    function automatic logic [16:0] model(input int w, input int a, input int b);
        int mask, ua, ub, q, r;
        logic [7:0] q8, r8;
        mask = (1 << w) - 1;
        ua = a & mask;
        ub = b & mask;
        if (ub == 0) begin
            q8 = 8'(mask);
            r8 = 8'(ua);
            return {1'b1, q8, r8};
        end
`ifdef DIV_SIGNED_EN
        if (ua >= (1 << (w - 1))) ua = ua - (1 << w);
        if (ub >= (1 << (w - 1))) ub = ub - (1 << w);
`endif
        q = (ua / ub) & mask;
        r = (ua % ub) & mask;
        q8 = 8'(q);
        r8 = 8'(r);
        return {1'b0, q8, r8};
    endfunction

    initial begin
        int lat, ndone;
        logic [7:0] ra, rb;

        // Reset held with start asserted: nothing may be accepted.
        rst = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 8'd3;
        start4 = 1'b0; dividend4 = 4'd0; divisor4 = 4'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_q", quotient, 8'h00);
        check("rst_r", remainder, 8'h00);
        check("rst_dbz", dbz, 1'b0);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("rst_release_busy", busy, 1'b0);

        // 200/7
        run8(8'd200, 8'd7, lat);
        check("t2_latency", lat, 9);
`ifdef DIV_SIGNED_EN
        check("t2_q", quotient, 8'hF8);
        check("t2_r", remainder, 8'h00);
`else
        check("t2_q", quotient, 8'd28);
        check("t2_r", remainder, 8'd4);
`endif
        check("t2_dbz", dbz, 1'b0);
        @(negedge clk);
        check("t2_done_pulse", done, 1'b0);
`ifdef DIV_SIGNED_EN
        check("t2_q_held", quotient, 8'hF8);
`else
        check("t2_q_held", quotient, 8'd28);
`endif

        // 5/0
        run8(8'd5, 8'd0, lat);
        check("t3_latency", lat, 1);
        check("t3_q", quotient, 8'hFF);
        check("t3_r", remainder, 8'd5);
        check("t3_dbz", dbz, 1'b1);
        @(negedge clk);
        check("t3_dbz_held", dbz, 1'b1);

        // 255/1 with an ignored 10/3 request mid-calculation
        @(negedge clk);
        dividend = 8'd255; divisor = 8'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("t4_busy", busy, 1'b1);
        @(negedge clk);
        @(negedge clk);
        dividend = 8'd10; divisor = 8'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 4;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("t4_latency", lat, 9);
        check("t4_q", quotient, 8'd255);
        check("t4_r", remainder, 8'd0);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t4_no_second_done", ndone, 0);

        // Reset 4 cycles into 100/9
        @(negedge clk);
        dividend = 8'd100; divisor = 8'd9; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_abort_busy", busy, 1'b0);
        check("t5_abort_done", done, 1'b0);
        check("t5_abort_q", quotient, 8'h00);
        check("t5_abort_r", remainder, 8'h00);
        ndone = 0;
        repeat (15) begin
            @(negedge clk);
            if (done) ndone++;
        end
        check("t5_no_done", ndone, 0);
        run8(8'd100, 8'd9, lat);
        check("t5_latency", lat, 9);
        check("t5_q", quotient, 8'd11);
        check("t5_r", remainder, 8'd1);

        // start held high: 12/5 then 13/4 after exactly one idle cycle
        @(negedge clk);
        dividend = 8'd12; divisor = 8'd5; start = 1'b1;
        @(negedge clk);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_latency1", lat, 9);
        check("b2b_q1", quotient, 8'd2);
        check("b2b_r1", remainder, 8'd2);
        @(negedge clk);
        check("b2b_idle_gap", busy, 1'b0);
        dividend = 8'd13; divisor = 8'd4;
        @(negedge clk);
        start = 1'b0;
        check("b2b_accept", busy, 1'b1);
        check("b2b_q_held", quotient, 8'd2);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("b2b_latency2", lat, 9);
        check("b2b_q2", quotient, 8'd3);
        check("b2b_r2", remainder, 8'd1);

`ifdef DIV_SIGNED_EN
        run8(8'hF9, 8'd2, lat);
        check("s_m7d2_q", quotient, 8'hFD);
        check("s_m7d2_r", remainder, 8'hFF);
        run8(8'h80, 8'hFF, lat);
        check("s_ovf_q", quotient, 8'h80);
        check("s_ovf_r", remainder, 8'h00);
        check("s_ovf_dbz", dbz, 1'b0);
`endif

        // Exhaustive WIDTH=4 sweep
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                run4(4'(a), 4'(b), lat);
                check($sformatf("w4_%0d_%0d", a, b),
                      {dbz4, 4'h0, quotient4, 4'h0, remainder4}, model(4, a, b));
                check($sformatf("w4_lat_%0d_%0d", a, b), lat, (b == 0) ? 1 : 5);
            end
        end

        // Random WIDTH=8 sweep, with periodic zero divisors
        for (int i = 0; i < 150; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = (i % 16 == 0) ? 8'd0 : 8'($urandom_range(0, 255));
            run8(ra, rb, lat);
            check($sformatf("w8_%0d_%0d", ra, rb),
                  {dbz, quotient, remainder}, model(8, int'(ra), int'(rb)));
            check($sformatf("w8_lat_%0d_%0d", ra, rb), lat, (rb == 8'd0) ? 1 : 9);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
